// File: rtl/multicycle_datapath_if.sv
// Shared instruction/data memory port for the multi-cycle core.
// One req/ready transfer at a time; master holds the request until ready.
interface multicycle_datapath_if #(
   parameter int WIDTH = 32
);
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXECUTE/MEM/WB sequencer
// over a single shared memory port, with halt-on-illegal and retire count.
module multicycle_datapath #(
   parameter int              WIDTH          = 32,
   parameter int              ADDR_BITS      = 5,
   parameter int              REG_FILE_DEPTH = 32,
   parameter logic [WIDTH-1:0] RESET_PC      = 32'h0000_0000,
   parameter int              CNT_BITS       = 32
) (
   input  logic                CLK,
   input  logic                RST,
   multicycle_datapath_if.master mem,
   output logic [WIDTH-1:0]    PC,
   output logic                Halted,
   output logic [CNT_BITS-1:0] Instr_Retired
);
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2b;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_SLT   = 6'h2a;

   state_t               state;
   logic [WIDTH-1:0]     ir, a, b, alu_out, mdr;
   logic [WIDTH-1:0]     rf [REG_FILE_DEPTH];

   logic [5:0]           op, funct;
   logic [ADDR_BITS-1:0] rs, rt, rd, wa;
   logic [WIDTH-1:0]     simm, rd_rs, rd_rt, alu_r, wd;
   logic                 legal;

   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign funct = ir[5:0];
   assign simm  = {{(WIDTH-16){ir[15]}}, ir[15:0]};
   assign rd_rs = (rs == '0) ? '0 : rf[rs];
   assign rd_rt = (rt == '0) ? '0 : rf[rt];
   assign wa    = (op == OP_R) ? rd : rt;
   assign wd    = (op == OP_LW) ? mdr : alu_out;

   always_comb begin
      legal = 1'b0;
      unique case (op)
         OP_R:    legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
         OP_J, OP_BEQ, OP_ADDI,
         OP_LW, OP_SW: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      alu_r = '0;
      unique case (funct)
         F_ADD:   alu_r = a + b;
         F_SUB:   alu_r = a - b;
         F_AND:   alu_r = a & b;
         F_OR:    alu_r = a | b;
         F_SLT:   alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         default: alu_r = '0;
      endcase
   end

   // The request is gated by reset so an abandoned transfer drops at once.
   assign mem.mem_req   = RST & (state == S_FETCH || state == S_MEM);
   assign mem.mem_we    = RST & (state == S_MEM) & (op == OP_SW);
   assign mem.mem_addr  = (state == S_MEM)   ? alu_out :
                          (state == S_FETCH) ? PC : '0;
   assign mem.mem_wdata = (state == S_MEM && op == OP_SW) ? b : '0;
   assign Halted        = (state == S_HALT);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state         <= S_FETCH;
         PC            <= RESET_PC;
         ir            <= '0;
         a             <= '0;
         b             <= '0;
         alu_out       <= '0;
         mdr           <= '0;
         Instr_Retired <= '0;
         for (int i = 0; i < REG_FILE_DEPTH; i++) rf[i] <= '0;
      end else begin
         unique case (state)
            S_FETCH: if (mem.mem_ready) begin
               ir    <= mem.mem_rdata;
               PC    <= PC + WIDTH'(4);
               state <= S_DECODE;
            end
            S_DECODE: begin
               a       <= rd_rs;
               b       <= rd_rt;
               alu_out <= PC + (simm << 2);
               state   <= legal ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
               unique case (op)
                  OP_R: begin
                     alu_out <= alu_r;
                     state   <= S_WB;
                  end
                  OP_ADDI: begin
                     alu_out <= a + simm;
                     state   <= S_WB;
                  end
                  OP_LW, OP_SW: begin
                     alu_out <= a + simm;
                     state   <= S_MEM;
                  end
                  OP_BEQ: begin
                     if (a == b) PC <= alu_out;
                     Instr_Retired <= Instr_Retired + CNT_BITS'(1);
                     state         <= S_FETCH;
                  end
                  default: begin
                     PC <= {PC[WIDTH-1:WIDTH-4], ir[25:0], 2'b00};
                     Instr_Retired <= Instr_Retired + CNT_BITS'(1);
                     state         <= S_FETCH;
                  end
               endcase
            end
            S_MEM: if (mem.mem_ready) begin
               if (op == OP_SW) begin
                  Instr_Retired <= Instr_Retired + CNT_BITS'(1);
                  state         <= S_FETCH;
               end else begin
                  mdr   <= mem.mem_rdata;
                  state <= S_WB;
               end
            end
            S_WB: begin
               if (wa != '0) rf[wa] <= wd;
               Instr_Retired <= Instr_Retired + CNT_BITS'(1);
               state         <= S_FETCH;
            end
            S_HALT: state <= S_HALT;
            default: state <= S_HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: small programs, wait states,
// illegal-opcode halt and asynchronous reset during a store.
module tb_multicycle_datapath;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        ready = 1'b1;
   logic [31:0] PC;
   logic        Halted;
   logic [31:0] retired;
   logic [31:0] mem [256];
   int          checks = 0;
   int          errors = 0;

   multicycle_datapath_if #(.WIDTH(32)) bus ();

   multicycle_datapath dut (
      .CLK           (CLK),
      .RST           (RST),
      .mem           (bus),
      .PC            (PC),
      .Halted        (Halted),
      .Instr_Retired (retired)
   );

   always #5 CLK = ~CLK;

   assign bus.mem_ready = ready;
   assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

   always @(posedge CLK)
      if (bus.mem_req && bus.mem_we && ready)
         mem[bus.mem_addr[9:2]] = bus.mem_wdata;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      // Single addi, reset values checked while RST is low
      clear_mem();
      mem[0] = 32'h2001_0005;
      mem[1] = 32'hAC01_0080;
      ready  = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("rst_pc", PC, 32'h0);
      check("rst_halted", {31'h0, Halted}, 32'h0);
      check("rst_retired", retired, 32'h0);
      check("rst_req", {31'h0, bus.mem_req}, 32'h0);
      check("rst_we", {31'h0, bus.mem_we}, 32'h0);
      check("rst_addr", bus.mem_addr, 32'h0);
      check("rst_wdata", bus.mem_wdata, 32'h0);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      check("c1_req", {31'h0, bus.mem_req}, 32'h1);
      check("c1_addr", bus.mem_addr, 32'h0);
      tick(4);
      check("addi_pc", PC, 32'h4);
      check("addi_retired", retired, 32'h1);
      tick(4);
      check("addi_r1", mem[32], 32'h5);

      // Arithmetic, store/load, register 0 discard
      clear_mem();
      mem[0]  = 32'h2001_0007;
      mem[1]  = 32'h2002_0003;
      mem[2]  = 32'h0022_1822;
      mem[3]  = 32'h0041_202A;
      mem[4]  = 32'hAC03_0040;
      mem[5]  = 32'h8C05_0040;
      mem[6]  = 32'hAC04_0044;
      mem[7]  = 32'hAC05_0048;
      mem[8]  = 32'h2000_0009;
      mem[9]  = 32'hAC00_004C;
      mem[19] = 32'h0000_DEAD;
      do_reset();
      tick(24);
      check("prog_ret24", retired, 32'h5);
      tick(1);
      check("prog_ret25", retired, 32'h6);
      check("prog_pc25", PC, 32'h18);
      check("sw_sub", mem[16], 32'h4);
      tick(8);
      check("slt_r4", mem[17], 32'h1);
      check("lw_r5", mem[18], 32'h4);
      tick(8);
      check("r0_zero", mem[19], 32'h0);
      check("prog_ret", retired, 32'd10);

      // Branches and jumps
      clear_mem();
      mem[0] = 32'h2001_0001;
      mem[1] = 32'h1020_0003;
      mem[2] = 32'h0800_0004;
      mem[4] = 32'h1000_0003;
      mem[8] = 32'h0800_0100;
      do_reset();
      tick(4);
      tick(3);
      check("beq_nt_pc", PC, 32'h8);
      tick(3);
      check("j_pc", PC, 32'h10);
      tick(3);
      check("beq_t_pc", PC, 32'h20);
      tick(3);
      check("j100_pc", PC, 32'h400);
      check("br_ret", retired, 32'h5);

      // Wait states in FETCH and in a lw MEM phase
      clear_mem();
      mem[0]  = 32'h8C07_0040;
      mem[1]  = 32'hAC07_0044;
      mem[16] = 32'h1234_5678;
      ready = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("fw_req", {31'h0, bus.mem_req}, 32'h1);
         check("fw_we", {31'h0, bus.mem_we}, 32'h0);
         check("fw_addr", bus.mem_addr, 32'h0);
      end
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      check("fw_pc", PC, 32'h4);
      tick(2);
      for (int i = 0; i < 3; i++) begin
         check("mw_req", {31'h0, bus.mem_req}, 32'h1);
         check("mw_we", {31'h0, bus.mem_we}, 32'h0);
         check("mw_addr", bus.mem_addr, 32'h40);
         if (i < 2) tick(1);
      end
      ready = 1'b1;
      tick(1);
      check("lw_ret9", retired, 32'h0);
      tick(1);
      check("lw_ret10", retired, 32'h1);
      tick(4);
      check("lw_data", mem[17], 32'h1234_5678);

      // Illegal opcode halts; reset recovers
      clear_mem();
      mem[0] = 32'h2001_0005;
      mem[1] = 32'hFC00_0000;
      do_reset();
      tick(5);
      check("ill_pc", PC, 32'h8);
      check("ill_h5", {31'h0, Halted}, 32'h0);
      tick(1);
      check("ill_h6", {31'h0, Halted}, 32'h1);
      tick(4);
      check("halt_req", {31'h0, bus.mem_req}, 32'h0);
      check("halt_pc", PC, 32'h8);
      check("halt_ret", retired, 32'h1);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("hrst_pc", PC, 32'h0);
      check("hrst_halted", {31'h0, Halted}, 32'h0);
      @(negedge CLK);
      RST = 1'b1;

      // Asynchronous reset during a stalled store
      clear_mem();
      mem[0] = 32'h2001_0005;
      mem[1] = 32'hAC01_0040;
      do_reset();
      tick(5);
      ready = 1'b0;
      tick(2);
      check("sw_req", {31'h0, bus.mem_req}, 32'h1);
      check("sw_we", {31'h0, bus.mem_we}, 32'h1);
      check("sw_addr", bus.mem_addr, 32'h40);
      check("sw_wdata", bus.mem_wdata, 32'h5);
      #2;
      RST = 1'b0;
      #1;
      check("ar_req", {31'h0, bus.mem_req}, 32'h0);
      check("ar_ret", retired, 32'h0);
      check("ar_pc", PC, 32'h0);
      ready = 1'b1;
      @(negedge CLK);
      check("ar_mem", mem[16], 32'h0);
      RST = 1'b1;
      #1;
      check("ar_req2", {31'h0, bus.mem_req}, 32'h1);
      check("ar_addr2", bus.mem_addr, 32'h0);
      tick(8);
      check("ar_ret2", retired, 32'h2);
      check("ar_store", mem[16], 32'h5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
